// File: rtl/sigmoid_alippi_pwl_pkg.sv
// sigmoid_pkg: shared widths and types for the power-of-two PWL sigmoid
package sigmoid_pkg;
    localparam int DEF_INT_BITS = 7;
    localparam int DEF_FRAC_BITS = 8;
    localparam int IN_W = 1 + DEF_INT_BITS + DEF_FRAC_BITS;
    localparam int OUT_W = DEF_FRAC_BITS + 1;
    localparam int N_W = DEF_FRAC_BITS + 2;
    typedef logic signed [IN_W-1:0] act_t;
    typedef logic [OUT_W-1:0] sig_t;
endpackage

// File: rtl/sigmoid_alippi_pwl_abs.sv
// twos_complement_abs: saturated magnitude and sign of a two's-complement value
module twos_complement_abs
    import sigmoid_pkg::*;
#(
    parameter int W = IN_W
) (
    input  logic [W-1:0] x_i,
    output logic [W-2:0] mag_o,
    output logic         neg_o
);
    logic [W-1:0] m;
    // negate when negative; only the most-negative code overflows, so clamp it
    always_comb begin
        neg_o = x_i[W-1];
        m = neg_o ? -x_i : x_i;
        mag_o = m[W-1] ? '1 : m[W-2:0];
    end
endmodule

// File: rtl/sigmoid_alippi_pwl.sv
// sigmoid_alippi_pwl: registered multiplier-free PWL sigmoid, one cycle latency
module sigmoid_alippi_pwl
    import sigmoid_pkg::*;
#(
    parameter int INT_BITS = DEF_INT_BITS,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid_i,
    input  logic [INT_BITS+FRAC_BITS:0]     x_i,
    output logic                            out_valid_o,
    output logic [FRAC_BITS:0]              y_o
);
    localparam int XW = 1 + INT_BITS + FRAC_BITS;
    localparam int YW = FRAC_BITS + 1;
    localparam int NW = FRAC_BITS + 2;
    logic [XW-2:0]     mag;
    logic              neg;
    logic [NW-1:0]     n;
    logic [NW-1:0]     s;
    logic [INT_BITS:0] sh;
    logic [YW-1:0]     y_d;
    logic [YW-1:0]     y_q;
    logic              vld_q;

    twos_complement_abs #(.W(XW)) u_abs (
        .x_i   (x_i),
        .mag_o (mag),
        .neg_o (neg)
    );

    // n = 0.5 - F/4 scaled by 2^(FRAC+2), shifted down by I+2; mirror for x >= 0
    always_comb begin
        n = NW'(2 ** (FRAC_BITS + 1)) - NW'(mag[FRAC_BITS-1:0]);
        sh = {1'b0, mag[XW-2:FRAC_BITS]} + (INT_BITS + 1)'(2);
        s = (sh >= (INT_BITS + 1)'(NW)) ? '0 : n >> sh;
        y_d = neg ? s[YW-1:0] : YW'(2 ** FRAC_BITS) - s[YW-1:0];
    end

    // output register: valid follows input, y holds across invalid cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_valid_i;
            if (in_valid_i) y_q <= y_d;
        end
    end

    assign y_o = y_q;
    assign out_valid_o = vld_q;
endmodule

// File: tb/tb_sigmoid_alippi_pwl.sv
// tb_sigmoid_alippi_pwl: scoreboard bench for the PWL sigmoid
module tb_sigmoid_alippi_pwl;
    import sigmoid_pkg::*;

    typedef struct {
        bit   v;
        bit   mono;
        act_t x;
        int   y;
    } exp_t;

    logic clk;
    logic rst;
    logic in_valid;
    act_t x;
    logic out_valid;
    sig_t y;
    act_t ref_x;
    logic [IN_W-2:0] ref_mag;
    logic ref_neg;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int hold_y = 0;
    int prev_y = 0;

    sigmoid_alippi_pwl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .x_i         (x),
        .out_valid_o (out_valid),
        .y_o         (y)
    );

    twos_complement_abs #(.W(IN_W)) u_ref_abs (
        .x_i   (ref_x),
        .mag_o (ref_mag),
        .neg_o (ref_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input act_t xv);
        int v, a, i, f, n, s;
        v = xv;
        a = (v < 0) ? -v : v;
        if (a > 32767) a = 32767;
        i = a / 256;
        f = a % 256;
        n = 512 - f;
        s = (i + 2 >= 10) ? 0 : n / (1 << (i + 2));
        return (v < 0) ? s : 256 - s;
    endfunction

    task automatic drive(input logic v, input act_t xv, input bit mono);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        x = xv;
        e.v = v;
        e.mono = mono;
        e.x = xv;
        e.y = v ? model(xv) : 0;
        q.push_back(e);
    endtask

    task automatic drive_exp(input act_t xv, input int yv);
        check($sformatf("model x=%h", xv), model(xv), yv);
        drive(1'b1, xv, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check($sformatf("out_valid x=%h", e.x), int'(out_valid), int'(e.v));
            if (e.v) begin
                check($sformatf("y x=%h", e.x), int'(y), e.y);
                hold_y = e.y;
                if (e.mono) begin
                    check($sformatf("mono x=%h", e.x), int'(int'(y) >= prev_y), 1);
                    prev_y = int'(y);
                end
            end else begin
                check($sformatf("hold x=%h", e.x), int'(y), hold_y);
            end
        end
    end

    initial begin
        logic [31:0] rv;
        act_t sx;
        rst = 1'b1;
        in_valid = 1'b1;
        x = 16'h0100;
        ref_x = 16'h8000;
        #1;
        check("abs 8000", int'(ref_mag), 32767);
        ref_x = 16'hFF00;
        #1;
        check("abs FF00", int'(ref_mag), 256);
        check("abs sign FF00", int'(ref_neg), 1);
        repeat (3) @(posedge clk);
        #1;
        check("reset y", int'(y), 0);
        check("reset out_valid", int'(out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        drive_exp(16'h0100, 192);
        drive_exp(16'h0000, 128);
        drive_exp(16'hFF00, 64);
        drive_exp(16'hFF80, 96);
        drive_exp(16'h0080, 160);
        drive_exp(16'h0280, 232);
        drive_exp(16'hFD80, 24);
        drive_exp(16'h0800, 256);
        drive_exp(16'hF800, 0);
        drive_exp(16'h7FFF, 256);
        drive_exp(16'h8000, 0);
        drive(1'b1, 16'h0100, 1'b0);
        drive(1'b0, 16'h0280, 1'b0);
        drive(1'b0, 16'h0000, 1'b0);
        drive(1'b1, 16'hFF80, 1'b0);
        drive(1'b0, 16'h7FFF, 1'b0);
        for (int i = 0; i < 5000; i++) begin
            rv = $urandom;
            sx = (i % 2 == 0) ? rv[15:0] : {{4{rv[11]}}, rv[11:0]};
            drive(1'b1, sx, 1'b0);
        end
        prev_y = 0;
        for (int i = -32768; i < 32768; i++) begin
            sx = i[15:0];
            drive(1'b1, sx, 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
